// File: rtl/inv_mixcolumns_xor_if.sv
// Handshake bundle for the inverse AddRoundKey + InvMixColumns stage.
// The master side is the upstream/downstream environment; the slave side is the stage itself.
interface inv_mixcolumns_xor_if #(
    parameter int unsigned NCOL = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [32*NCOL-1:0]     in_state;
    logic [32*NCOL-1:0]     in_key;
    logic                   skip_mix;
    logic                   out_valid;
    logic                   out_ready;
    logic [32*NCOL-1:0]     out_state;
    logic                   busy;

    modport master (
        output in_valid, in_state, in_key, skip_mix, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_key, skip_mix, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_mixcolumns_xor.sv
// AES inverse round stage: AddRoundKey followed by InvMixColumns, one column per clock
// through a single shared column unit. skip_mix bypasses InvMixColumns for the final round.
module inv_mixcolumns_xor #(
    parameter int unsigned NCOL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_mixcolumns_xor_if.slave  bus
);
    localparam int unsigned W  = 32 * NCOL;
    localparam int unsigned CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [W-1:0]  work;
    logic          skip_q;
    logic [W-1:0]  out_state_q;
    logic          out_valid_q;
    logic          in_ready_q;
    logic [31:0]   col_in;
    logic [31:0]   col_mixed;
    logic [31:0]   col_res;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Select the work column addressed by the column counter (column 0 is the MSB word).
    always_comb begin
        col_in = '0;
        for (int unsigned c = 0; c < NCOL; c++) begin
            if (col == c[CW-1:0]) begin
                col_in = work[(NCOL-1-c)*32 +: 32];
            end
        end
    end

    // Shared InvMixColumns column unit, with bypass for the final inverse round.
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        col_mixed[31:24] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        col_mixed[23:16] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        col_mixed[15:8]  = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        col_mixed[7:0]   = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        col_res = skip_q ? col_in : col_mixed;
    end

    // Control FSM, work register and progressively written result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            work        <= '0;
            skip_q      <= 1'b0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        work       <= bus.in_state ^ bus.in_key;
                        skip_q     <= bus.skip_mix;
                        col        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned c = 0; c < NCOL; c++) begin
                        if (col == c[CW-1:0]) begin
                            out_state_q[(NCOL-1-c)*32 +: 32] <= col_res;
                        end
                    end
                    col <= col + 1'b1;
                    if (col == LAST_COL) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_inv_mixcolumns_xor.sv
// Directed self-checking bench for inv_mixcolumns_xor.
module tb_inv_mixcolumns_xor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    logic [127:0] held;

    localparam logic [127:0] V1_STATE = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] V1_EXP   = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] V2_STATE = 128'h8e4ca3bf9bd95e9a09080b0acacbc8c9;
    localparam logic [127:0] V2_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

    inv_mixcolumns_xor_if #(.NCOL(4)) bus ();

    inv_mixcolumns_xor #(.NCOL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the accept happens at the following posedge.
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic sk);
        bus.in_state = s;
        bus.in_key   = k;
        bus.skip_mix = sk;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts clocks from the accept edge until out_valid is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_out(input logic [127:0] exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("release_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("release_state_kept", bus.out_state, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_state  = '1;
        bus.in_key    = '1;
        bus.skip_mix  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held for two clocks
        @(negedge clk);
        @(negedge clk);
        check("rst_out_state", bus.out_state, 128'd0);
        check("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("rst_busy", {127'b0, bus.busy}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 InvMixColumns vector, zero key
        send(V1_STATE, 128'd0, 1'b0);
        check("v1_in_ready_low", {127'b0, bus.in_ready}, 128'd0);
        check("v1_busy", {127'b0, bus.busy}, 128'd1);
        wait_done(cyc);
        check("v1_latency", 128'(cyc), 128'd4);
        check("v1_state", bus.out_state, V1_EXP);
        release_out(V1_EXP);

        // Key path: state ^ key reproduces vector 1
        send(V2_STATE, V2_KEY, 1'b0);
        wait_done(cyc);
        check("v2_latency", 128'(cyc), 128'd4);
        check("v2_state", bus.out_state, V1_EXP);
        release_out(V1_EXP);

        // Final-round bypass: XOR only
        send(128'd0, V2_KEY, 1'b1);
        wait_done(cyc);
        check("skip_latency", 128'(cyc), 128'd4);
        check("skip_state", bus.out_state, V2_KEY);
        release_out(V2_KEY);

        // Backpressure while upstream keeps offering new inputs
        send(V1_STATE, 128'd0, 1'b0);
        wait_done(cyc);
        check("bp_latency", 128'(cyc), 128'd4);
        held = V1_EXP;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_state = {$urandom, $urandom, $urandom, $urandom};
            bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_state_stable", bus.out_state, held);
            check("bp_in_ready_low", {127'b0, bus.in_ready}, 128'd0);
            check("bp_out_valid_high", {127'b0, bus.out_valid}, 128'd1);
        end
        bus.in_valid = 1'b0;
        release_out(held);
        // Nothing was queued during DONE
        @(negedge clk);
        check("bp_no_accept", {127'b0, bus.busy}, 128'd0);

        // Reset while RUN is processing column 2
        send(V2_STATE, V2_KEY, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_state", bus.out_state, 128'd0);
        check("midrst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("midrst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("midrst_busy", {127'b0, bus.busy}, 128'd0);
        @(negedge clk);
        send(V2_STATE, V2_KEY, 1'b0);
        wait_done(cyc);
        check("after_rst_latency", 128'(cyc), 128'd4);
        check("after_rst_state", bus.out_state, V1_EXP);
        release_out(V1_EXP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_mixcolumns_xor.md
Name: inv_mixcolumns_xor

Overview:
Inverse-cipher counterpart of the MixColumnsXOR encryption round stage, used by the AES-128 decryption datapath. It performs AddRoundKey (state XOR round key) and then InvMixColumns on a 128-bit state. It processes one 32-bit column per clock, which means one shared InvMixColumns column unit instead of four. The block sits between InvShiftRows/InvSubBytes and the next inverse round, with valid/ready handshakes on both sides.

Parameters:
- NCOL, 4, columns per state; fixed at 4 for AES-128. It also sets the column counter range.

Ports:
- clk  in  1  Single clock; all logic is rising-edge.
- rst_n  in  1  Synchronous, active-low reset.
- in_valid  in  1  in_state, in_key and skip_mix are valid.
- in_ready  out  1  Block can accept an input. High only in IDLE.
- in_state  in  128  Inverse-round state. Byte i is bits [127-8i:120-8i]; column c is bytes 4c..4c+3 (FIPS-197 column-major).
- in_key  in  128  Round key, same byte order as in_state.
- skip_mix  in  1  1 selects XOR only with InvMixColumns bypassed (final inverse round). Sampled at accept.
- out_valid  out  1  out_state holds a complete result.
- out_ready  in  1  Downstream accepts out_state.
- out_state  out  128  Result, same byte order.
- busy  out  1  High in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE, col counter to 0.
  - out_state=0, out_valid=0, in_ready=1, busy=0.
  - Reset overrides every other event, including mid-RUN and DONE. Any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at an edge: capture in_state^in_key into the work register, latch skip_mix, set col=0, go to RUN.
- RUN:
  - Each edge processes column col of the work register.
  - The result is InvMixColumns(column) using the matrix rows [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e] over GF(2^8) mod x^8+x^4+x^3+x+1. If skip_mix is latched, the column passes through unchanged.
  - The result is written to column col of out_state, then col increments.
  - After the edge that processes col=3, go to DONE.
  - Inputs that change during RUN have no effect.
- Latency: accept at edge E0 gives out_valid=1 after edge E4 (4 clocks). out_state columns update progressively during RUN. Only the DONE value is meaningful.
- DONE:
  - out_valid=1, in_ready=0.
  - out_state is held stable while out_ready=0, for any duration.
  - When out_valid&&out_ready at an edge: go to IDLE, out_valid=0. out_state keeps its value.
- No overlap: a new input is only accepted in IDLE, so in_valid in RUN or DONE is ignored and not queued.
- in_ready and out_valid are registered, with no combinational path from in_valid or out_ready.
- xtime: shift left by 1, then XOR with 0x1b if the old bit 7 was set. Multiply by 09/0b/0d/0e using xtime chains; no lookup tables.
- Back-to-back: when DONE is accepted at edge En, in_ready is high from En, so the next accept can occur at En+1.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks → out_state=0, out_valid=0, in_ready=1, busy=0.
- FIPS-197 vector, key=0, skip_mix=0, in_state=8e4da1bc9fdc589d01010101c6c6c6c6 → out_state=db135345f20a225c01010101c6c6c6c6, out_valid rising exactly 4 clocks after accept.
- Key path:
  - Inputs: in_key=000102030405060708090a0b0c0d0e0f, in_state=8e4ca3bf9bd95e9a09080b0acacbc8c9, skip_mix=0.
  - Expected: out_state=db135345f20a225c01010101c6c6c6c6.
- skip_mix=1, in_state=0, in_key=000102...0f → out_state=000102030405060708090a0b0c0d0e0f after 4 clocks.
- Backpressure and ignored inputs:
  - Hold out_ready=0 for 10 clocks in DONE while toggling in_valid and in_state.
  - Expected: out_state stays stable, in_ready=0, no new accept.
  - Then assert out_ready=1 → out_valid=0 and in_ready=1 next edge.
- Reset mid-op: assert rst_n=0 during the RUN clock with col=2 → next edge IDLE, out_state=0, out_valid=0. A following transaction with vector 2 then yields the correct result.
